// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: soc/eoc handshake toward the sample
// consumer, MSB-first binary search over an external 8-bit DAC and comparator.
module sar_adc_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       soc,
  input  logic       cmp,
  output logic       eoc,
  output logic [7:0] x,
  output logic [7:0] dac
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    CONV
  } state_e;

  state_e           state_q, state_d;
  logic             eoc_q, eoc_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       dac_q, dac_d;
  logic [2:0]       k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       kept;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      eoc_q   <= 1'b1;
      x_q     <= 8'h00;
      dac_q   <= 8'h00;
      k_q     <= 3'd7;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      eoc_q   <= eoc_d;
      x_q     <= x_d;
      dac_q   <= dac_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal is given its hold value before the case statement, so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    eoc_d   = eoc_q;
    x_d     = x_q;
    dac_d   = dac_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    kept       = dac_q;
    kept[k_q]  = cmp;

    unique case (state_q)
      IDLE: begin
        if (soc) begin
          eoc_d   = 1'b0;
          state_d = ACK;
        end
      end
      ACK: begin
        // The consumer must drop soc before the search begins.
        if (!soc) begin
          dac_d   = 8'h80;
          k_d     = 3'd7;
          cnt_d   = CNT_RELOAD;
          state_d = CONV;
        end
      end
      CONV: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (k_q != 3'd0) begin
          dac_d            = kept;
          dac_d[k_q - 3'd1] = 1'b1;
          k_d              = k_q - 3'd1;
          cnt_d            = CNT_RELOAD;
        end else begin
          // Result and DAC are committed together with eoc on the last decision.
          x_d     = kept;
          dac_d   = kept;
          eoc_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign eoc = eoc_q;
  assign x   = x_q;
  assign dac = dac_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl: SETTLE=2 and SETTLE=1 instances share
// the handshake and analog input, each with its own comparator model.
module tb_sar_adc_ctrl;

  logic       clock;
  logic       reset;
  logic       soc;
  logic [7:0] vin;

  logic       eoc2, eoc1;
  logic [7:0] x2, x1, dac2, dac1;
  logic       cmp2, cmp1;

  int checks = 0;
  int errors = 0;

  logic [7:0] q2[$];
  logic [7:0] q1[$];
  logic [7:0] last_x;
  int         hist[$];

  assign cmp2 = (vin >= dac2);
  assign cmp1 = (vin >= dac1);

  sar_adc_ctrl #(.SETTLE(2)) u_dut2 (
    .clock(clock), .reset(reset), .soc(soc), .cmp(cmp2),
    .eoc(eoc2), .x(x2), .dac(dac2)
  );

  sar_adc_ctrl #(.SETTLE(1)) u_dut1 (
    .clock(clock), .reset(reset), .soc(soc), .cmp(cmp1),
    .eoc(eoc1), .x(x1), .dac(dac1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one full request: soc held for `hold` edges, optional soc pulse
  // during CONV, then follows both instances edge by edge until done.
  task automatic convert(input logic [7:0] v, input int hold, input bit pulse);
    logic [7:0] tr[8];
    logic [7:0] code;
    logic [7:0] final_code;
    logic [7:0] d2_before, d1_before;
    code = 8'h00;
    for (int k = 7; k >= 0; k--) begin
      tr[7-k] = code | (8'h01 << k);
      if (v >= tr[7-k]) code = tr[7-k];
    end
    final_code = code;
    q2.push_back(final_code);
    q1.push_back(final_code);
    d2_before = dac2;
    d1_before = dac1;
    vin = v;
    soc = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); @(negedge clock);
      check("ack_eoc2", eoc2, 1'b0);
      check("ack_eoc1", eoc1, 1'b0);
      check("ack_dac2", dac2, d2_before);
      check("ack_dac1", dac1, d1_before);
      check("ack_x2", x2, last_x);
    end
    soc = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      @(posedge clock); @(negedge clock);
      if (pulse && j == 3) soc = 1'b1;
      if (pulse && j == 4) soc = 1'b0;
      if (j < 16) begin
        check("conv_eoc2", eoc2, 1'b0);
        check("conv_dac2", dac2, tr[j/2]);
        check("conv_x2_hold", x2, last_x);
      end else begin
        check("done_eoc2", eoc2, 1'b1);
        check("sb_q2_nonempty", q2.size(), 1);
        if (q2.size() > 0) check("done_x2", x2, q2.pop_front());
        check("done_dac2", dac2, final_code);
      end
      if (j < 8) begin
        check("conv_eoc1", eoc1, 1'b0);
        check("conv_dac1", dac1, tr[j]);
      end else if (j == 8) begin
        check("done_eoc1", eoc1, 1'b1);
        check("sb_q1_nonempty", q1.size(), 1);
        if (q1.size() > 0) check("done_x1", x1, q1.pop_front());
        check("done_dac1", dac1, final_code);
      end else begin
        check("idle_eoc1", eoc1, 1'b1);
        check("idle_x1_stable", x1, final_code);
      end
    end
    last_x = final_code;
    hist.push_back(int'(x2));
  endtask

  task automatic check_consumer(input int exp_sum, input logic exp_out);
    int sum;
    sum = 0;
    for (int i = hist.size() - 3; i < hist.size(); i++) sum += hist[i];
    check("consumer_sum", sum, exp_sum);
    check("consumer_out", (sum >= 164), exp_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    soc    = 1'b1;
    vin    = 8'h00;
    last_x = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); @(negedge clock);
      check("rst_eoc2", eoc2, 1'b1);
      check("rst_x2", x2, 8'h00);
      check("rst_dac2", dac2, 8'h00);
      check("rst_eoc1", eoc1, 1'b1);
      check("rst_dac1", dac1, 8'h00);
    end
    reset = 1'b0;
    soc   = 1'b0;
    @(posedge clock); @(negedge clock);
    check("post_rst_eoc2", eoc2, 1'b1);

    convert(8'hA5, 1, 1'b0);
    convert(8'h00, 1, 1'b0);
    convert(8'hFF, 1, 1'b0);
    convert(8'h5A, 6, 1'b1);

    // Abort a conversion five edges after E0.
    vin = 8'h90;
    soc = 1'b1;
    @(posedge clock); @(negedge clock);
    soc = 1'b0;
    @(posedge clock); @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); @(negedge clock);
    end
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    check("abort_eoc2", eoc2, 1'b1);
    check("abort_x2", x2, 8'h00);
    check("abort_dac2", dac2, 8'h00);
    check("abort_eoc1", eoc1, 1'b1);
    check("abort_x1", x1, 8'h00);
    reset  = 1'b0;
    last_x = 8'h00;
    @(posedge clock); @(negedge clock);
    convert(8'h3C, 1, 1'b0);

    for (int i = 0; i < 3; i++) convert(8'h37, 1, 1'b0);
    check_consumer(165, 1'b1);
    for (int i = 0; i < 3; i++) convert(8'h36, 1, 1'b0);
    check_consumer(162, 1'b0);

    check("sb_q2_drained", q2.size(), 0);
    check("sb_q1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
